// File: rtl/vx_skid_register.sv
// Two-entry elastic register for a valid/ready channel. valid_out, data_out and ready_in are all
// driven straight from flops. Optional stall counter enabled by defining VX_SKID_REG_PERF_EN.
module vx_skid_register #(
    parameter int DATAW      = 1,
    parameter int PASSTHRU   = 0,
    parameter int PERF_CTR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATAW-1:0]      data_in,
    output logic                  valid_out,
    output logic [DATAW-1:0]      data_out,
    input  logic                  ready_out
`ifdef VX_SKID_REG_PERF_EN
    ,
    output logic [PERF_CTR_W-1:0] perf_stalls
`endif
);

`ifndef VX_SKID_REG_PERF_EN
    logic [PERF_CTR_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

    generate
        if (PASSTHRU != 0) begin : g_passthru
            logic w_unused_clk_rst;

            assign ready_in         = ready_out;
            assign valid_out        = valid_in;
            assign data_out         = data_in;
            assign w_unused_clk_rst = clk ^ reset;
`ifdef VX_SKID_REG_PERF_EN
            assign perf_stalls = '0;
`endif
        end else begin : g_reg
            typedef enum logic [1:0] {
                S_EMPTY = 2'd0,
                S_ONE   = 2'd1,
                S_FULL  = 2'd2
            } state_t;

            state_t             r_state;
            state_t             w_state_next;
            logic               r_ready_in;
            logic               r_valid_out;
            logic [DATAW-1:0]   r_main;
            logic [DATAW-1:0]   r_skid;
            logic               w_push;
            logic               w_pop;
            logic               w_load_main;
            logic               w_main_from_skid;
            logic               w_load_skid;

            assign w_push = valid_in & r_ready_in;
            assign w_pop  = r_valid_out & ready_out;

            always_comb begin
                w_state_next     = r_state;
                w_load_main      = 1'b0;
                w_main_from_skid = 1'b0;
                w_load_skid      = 1'b0;
                case (r_state)
                    S_EMPTY: begin
                        if (w_push) begin
                            w_state_next = S_ONE;
                            w_load_main  = 1'b1;
                        end
                    end
                    S_ONE: begin
                        if (w_push && w_pop) begin
                            w_load_main = 1'b1;
                        end else if (w_push) begin
                            w_state_next = S_FULL;
                            w_load_skid  = 1'b1;
                        end else if (w_pop) begin
                            w_state_next = S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        // ready_in is low here, so only the drain of the skid entry can happen
                        if (w_pop) begin
                            w_state_next     = S_ONE;
                            w_main_from_skid = 1'b1;
                        end
                    end
                    default: w_state_next = S_EMPTY;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_state     <= S_EMPTY;
                    r_valid_out <= 1'b0;
                    r_ready_in  <= 1'b0;
                end else begin
                    r_state     <= w_state_next;
                    r_valid_out <= (w_state_next != S_EMPTY);
                    r_ready_in  <= (w_state_next != S_FULL);
                end
            end

            // Payload flops carry no reset; their content is meaningless while valid_out is low.
            always_ff @(posedge clk) begin
                if (w_load_main) begin
                    r_main <= data_in;
                end else if (w_main_from_skid) begin
                    r_main <= r_skid;
                end
                if (w_load_skid) begin
                    r_skid <= data_in;
                end
            end

            assign ready_in  = r_ready_in;
            assign valid_out = r_valid_out;
            assign data_out  = r_main;

`ifdef VX_SKID_REG_PERF_EN
            logic [PERF_CTR_W-1:0] r_perf_stalls;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_perf_stalls <= '0;
                end else if (r_valid_out && !ready_out) begin
                    r_perf_stalls <= r_perf_stalls + 1'b1;
                end
            end

            assign perf_stalls = r_perf_stalls;
`endif

`ifndef SYNTHESIS
            a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
                !((r_state == S_FULL) && w_push));
            a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!reset)
                (r_valid_out && !ready_out) |=> (r_valid_out && $stable(r_main)));
`endif
        end
    endgenerate

endmodule

// File: tb/tb_vx_skid_register.sv
// Bench for vx_skid_register: directed scenarios plus a random run, all checked against a
// two-slot FIFO reference model; also checks a PASSTHRU=1 instance.
module tb_vx_skid_register;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_out;

    logic          p_valid_in;
    logic          p_ready_in;
    logic [DW-1:0] p_data_in;
    logic          p_valid_out;
    logic [DW-1:0] p_data_out;
    logic          p_ready_out;

`ifdef VX_SKID_REG_PERF_EN
    logic [31:0]   perf_stalls;
    logic [31:0]   p_perf_stalls;
`endif

    always #5 clk = ~clk;

    vx_skid_register #(.DATAW(DW), .PASSTHRU(0), .PERF_CTR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out)
`ifdef VX_SKID_REG_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    vx_skid_register #(.DATAW(DW), .PASSTHRU(1), .PERF_CTR_W(32)) dut_pt (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (p_valid_in),
        .ready_in  (p_ready_in),
        .data_in   (p_data_in),
        .valid_out (p_valid_out),
        .data_out  (p_data_out),
        .ready_out (p_ready_out)
`ifdef VX_SKID_REG_PERF_EN
        ,
        .perf_stalls (p_perf_stalls)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a FIFO of capacity two; accepting is blocked for one cycle after reset.
    logic [DW-1:0] mq[$];
    bit            m_blk = 1'b1;
    int            m_pushes = 0;
    int            dut_pops = 0;

    function automatic bit m_ready();
        return !m_blk && (mq.size() < 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycle(input string tag);
        bit pu;
        bit po;
        if (valid_out === 1'b1 && ready_out) dut_pops++;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_blk = 1'b1;
        end else begin
            pu = valid_in && m_ready();
            po = (mq.size() > 0) && ready_out;
            if (po) void'(mq.pop_front());
            if (pu) begin
                mq.push_back(data_in);
                m_pushes++;
            end
            m_blk = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_ready_in"}, {31'd0, ready_in}, {31'd0, m_ready()});
        chk({tag, "_valid_out"}, {31'd0, valid_out}, {31'd0, (mq.size() > 0)});
        if (mq.size() > 0) chk({tag, "_data_out"}, {24'd0, data_out}, {24'd0, mq[0]});
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b1; data_in = 8'h55; ready_out = 1'b0;
        p_valid_in = 1'b0; p_data_in = '0; p_ready_out = 1'b0;

        // Reset held with valid_in high
        repeat (3) cycle("t1_rst");
        chk("t1_rdy_low", {31'd0, ready_in}, 32'd0);
        chk("t1_vld_low", {31'd0, valid_out}, 32'd0);
        reset = 1'b1; valid_in = 1'b0;
        cycle("t1_rel");
        chk("t1_rdy_rise", {31'd0, ready_in}, 32'd1);

        // Back-to-back streaming
        ready_out = 1'b1; valid_in = 1'b1;
        data_in = 8'h11; cycle("t2"); chk("t2_d11", {24'd0, data_out}, 32'h11);
        data_in = 8'h22; cycle("t2"); chk("t2_d22", {24'd0, data_out}, 32'h22);
        data_in = 8'h33; cycle("t2"); chk("t2_d33", {24'd0, data_out}, 32'h33);
        chk("t2_rdy", {31'd0, ready_in}, 32'd1);
        valid_in = 1'b0; cycle("t2_drain");

        // Fill, blocked third push, then drain
        ready_out = 1'b0; valid_in = 1'b1;
        data_in = 8'hA1; cycle("t3");
        data_in = 8'hA2; cycle("t3"); chk("t3_full_rdy", {31'd0, ready_in}, 32'd0);
        data_in = 8'hA3; cycle("t3"); chk("t3_blocked_rdy", {31'd0, ready_in}, 32'd0);
        chk("t3_head_a1", {24'd0, data_out}, 32'hA1);
        ready_out = 1'b1;
        cycle("t3"); chk("t3_head_a2", {24'd0, data_out}, 32'hA2);
        cycle("t3"); chk("t3_head_a3", {24'd0, data_out}, 32'hA3);
        valid_in = 1'b0;
        cycle("t3"); chk("t3_empty", {31'd0, valid_out}, 32'd0);

        // Reset while full
        ready_out = 1'b0; valid_in = 1'b1;
        data_in = 8'hB1; cycle("t4");
        data_in = 8'hB2; cycle("t4");
        reset = 1'b0; valid_in = 1'b0;
        cycle("t4_rst"); chk("t4_vld_low", {31'd0, valid_out}, 32'd0);
        reset = 1'b1; cycle("t4_rel");
        valid_in = 1'b1; data_in = 8'hC1; ready_out = 1'b1;
        cycle("t4"); chk("t4_first_c1", {24'd0, data_out}, 32'hC1);
        valid_in = 1'b0; cycle("t4_drain");

        // Random traffic; producer holds its offer until accepted
        m_pushes = 0; dut_pops = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!(valid_in && !m_ready())) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = 8'($urandom);
            end
            ready_out = 1'($urandom_range(0, 1));
            cycle("t5");
        end
        valid_in = 1'b0; ready_out = 1'b1;
        repeat (3) cycle("t5_drain");
        chk("t5_pop_count", dut_pops, m_pushes);

`ifdef VX_SKID_REG_PERF_EN
        reset = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
        cycle("t6_rst");
        reset = 1'b1; cycle("t6_rel");
        valid_in = 1'b1; data_in = 8'h77; cycle("t6");
        valid_in = 1'b0;
        repeat (7) cycle("t6_stall");
        chk("t6_perf_stalls", perf_stalls, 32'd7);
        chk("t6_pt_perf_zero", p_perf_stalls, 32'd0);
`endif

        // PASSTHRU instance: outputs follow inputs in the same cycle
        for (int i = 0; i < 4; i++) begin
            p_valid_in  = 1'($urandom_range(0, 1));
            p_ready_out = 1'($urandom_range(0, 1));
            p_data_in   = 8'($urandom);
            #1;
            chk("pt_valid", {31'd0, p_valid_out}, {31'd0, p_valid_in});
            chk("pt_ready", {31'd0, p_ready_in}, {31'd0, p_ready_out});
            chk("pt_data", {24'd0, p_data_out}, {24'd0, p_data_in});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
